// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo responder and its bench.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {IDLE, ARM, HOLD, GAP} echo_state_e;

    localparam int UART_BITS_PER_FRAME = 11;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a combinational head output and a separately tracked count.
`timescale 1ns/1ps
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != FULL_COUNT) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rdata = mem[rd_ptr_reg];
    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/uart_echo_responder.sv
// Echo node: captures bytes from UART_RX, buffers them and re-offers each one to UART_TX,
// paced by baud_tick so consecutive frames never overlap.
`timescale 1ns/1ps
module uart_echo_responder
    import uart_pkg::*;
#(
    parameter int                   DATA_WIDTH     = 8,
    parameter int                   FIFO_DEPTH     = 8,
    parameter int                   BITS_PER_FRAME = UART_BITS_PER_FRAME,
    parameter int                   GAP_TICKS      = 2,
    parameter logic [DATA_WIDTH-1:0] XOR_MASK      = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          baud_tick,
    input  logic                          rx_data_valid,
    input  logic [DATA_WIDTH-1:0]         rx_data_out,
    output logic                          tx_data_ready,
    output logic [DATA_WIDTH-1:0]         tx_data_in,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int FRAME_TICKS = BITS_PER_FRAME + GAP_TICKS;
    localparam int GW          = $clog2(FRAME_TICKS + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(FRAME_TICKS);

    echo_state_e           state_reg;
    echo_state_e           state_next;
    logic                  tx_ready_reg;
    logic                  tx_ready_next;
    logic [DATA_WIDTH-1:0] tx_data_reg;
    logic [DATA_WIDTH-1:0] tx_data_next;
    logic [GW-1:0]         gap_cnt_reg;
    logic [GW-1:0]         gap_cnt_next;
    logic                  rx_valid_d_reg;
    logic                  overflow_reg;

    logic                  rx_rise;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;

    // rx_data_valid is a level; only its rising edge counts as a new byte.
    assign rx_rise = rx_data_valid && !rx_valid_d_reg;

    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_rise),
        .pop   (fifo_pop),
        .wdata (rx_data_out ^ XOR_MASK),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            tx_ready_reg   <= 1'b0;
            tx_data_reg    <= '0;
            gap_cnt_reg    <= '0;
            rx_valid_d_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tx_ready_reg   <= tx_ready_next;
            tx_data_reg    <= tx_data_next;
            gap_cnt_reg    <= gap_cnt_next;
            rx_valid_d_reg <= rx_data_valid;
            if (rx_rise && fifo_full && !fifo_pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        tx_ready_next = tx_ready_reg;
        tx_data_next  = tx_data_reg;
        gap_cnt_next  = gap_cnt_reg;
        fifo_pop      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                if (baud_tick) begin
                    tx_data_next  = fifo_head;
                    tx_ready_next = 1'b1;
                    fifo_pop      = 1'b1;
                    state_next    = HOLD;
                end
            end
            HOLD: begin
                // Ready spans exactly one tick, so TX launches exactly one frame.
                if (baud_tick) begin
                    tx_ready_next = 1'b0;
                    gap_cnt_next  = '0;
                    state_next    = GAP;
                end
            end
            GAP: begin
                if (baud_tick) begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                    if (gap_cnt_next == GAP_LAST) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_data_ready = tx_ready_reg;
    assign tx_data_in    = tx_data_reg;
    assign tx_busy       = (state_reg != IDLE);
    assign overflow      = overflow_reg;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Scoreboard bench for uart_echo_responder: stimulus queues expected echoes, monitors check them.
`timescale 1ns/1ps
module tb_uart_echo_responder;
    import uart_pkg::*;

    localparam int FRAME_SPACING = UART_BITS_PER_FRAME + 2 + 2;
    localparam int GAP_COUNT     = UART_BITS_PER_FRAME + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       auto_tick = 1'b0;
    logic       man_tick = 1'b0;
    logic       baud_tick;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_x_valid = 1'b0;
    logic [7:0] rx_x_data = 8'h00;

    logic       ready, busy, overflow;
    logic [7:0] data_in;
    logic [3:0] count;
    logic       ready_x, busy_x, overflow_x;
    logic [7:0] data_in_x;
    logic [3:0] count_x;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_x_q[$];

    bit tick_en = 1'b0;
    int phase = 0;
    bit chk_width = 1'b1;
    bit chk_hold = 1'b1;
    bit chk_spacing = 1'b0;
    bit spacing_valid = 1'b0;
    int tick_cnt = 0;
    int last_rise_tick = 0;
    int fall_tick = 0;
    int hi_clks = 0;
    int hi_ticks = 0;
    int peak = 0;
    int rises_x = 0;
    logic ready_prev = 1'b0, busy_prev = 1'b0, ready_x_prev = 1'b0;

    assign baud_tick = auto_tick | man_tick;

    uart_echo_responder #(
        .DATA_WIDTH(8), .FIFO_DEPTH(8), .BITS_PER_FRAME(UART_BITS_PER_FRAME),
        .GAP_TICKS(2), .XOR_MASK(8'h00)
    ) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .rx_data_valid(rx_valid), .rx_data_out(rx_data),
        .tx_data_ready(ready), .tx_data_in(data_in), .tx_busy(busy),
        .fifo_count(count), .overflow(overflow)
    );

    uart_echo_responder #(
        .DATA_WIDTH(8), .FIFO_DEPTH(8), .BITS_PER_FRAME(UART_BITS_PER_FRAME),
        .GAP_TICKS(2), .XOR_MASK(8'hFF)
    ) dut_x (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .rx_data_valid(rx_x_valid), .rx_data_out(rx_x_data),
        .tx_data_ready(ready_x), .tx_data_in(data_in_x), .tx_busy(busy_x),
        .fifo_count(count_x), .overflow(overflow_x)
    );

    always #50 clk = ~clk;

    // One baud tick per 10 clocks while enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (tick_en) begin
            phase = (phase == 9) ? 0 : phase + 1;
            auto_tick = (phase == 9);
        end else begin
            auto_tick = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every ready rise and checks frame timing.
    initial forever begin
        @(negedge clk);
        if (baud_tick) tick_cnt++;
        if (ready && !ready_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_echo: got %0h, expected no echo", data_in);
            end else begin
                check("echo_data", data_in, exp_q.pop_front());
            end
            if (chk_spacing && spacing_valid)
                check("rise_spacing_ticks", tick_cnt - last_rise_tick, FRAME_SPACING);
            last_rise_tick = tick_cnt;
            spacing_valid = 1'b1;
            hi_clks = 0;
            hi_ticks = 0;
        end
        if (ready) begin
            hi_clks++;
            if (baud_tick) hi_ticks++;
        end
        if (!ready && ready_prev) begin
            if (chk_width) check("ready_width_clks", hi_clks, 10);
            if (chk_hold) check("ticks_under_ready", hi_ticks, 1);
            fall_tick = tick_cnt;
        end
        if (!busy && busy_prev && chk_hold)
            check("gap_ticks", tick_cnt - fall_tick, GAP_COUNT);
        if (int'(count) > peak) peak = int'(count);
        if (ready_x && !ready_x_prev) begin
            rises_x++;
            if (exp_x_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_echo_x: got %0h, expected no echo", data_in_x);
            end else begin
                check("echo_data_x", data_in_x, exp_x_q.pop_front());
            end
        end
        ready_prev = ready;
        busy_prev = busy;
        ready_x_prev = ready_x;
    end

    task automatic send(input logic [7:0] b, input logic [7:0] expv);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_valid = 1'b1;
        exp_q.push_back(expv);
        $display("send %02h expect %02h", b, expv);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if (!busy && count == 0 && !busy_x && count_x == 0) done = 1'b1;
        end
        check({name, "_idle"}, done, 1);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic pulse_reset(input string name);
        @(negedge clk);
        #10;
        rst = 1'b0;
        #1;
        check({name, "_ready"}, ready, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_count"}, count, 0);
        check({name, "_overflow"}, overflow, 0);
        check({name, "_data"}, data_in, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_data", data_in, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_ready_x", ready_x, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        tick_en = 1'b1;

        // 1: single byte
        send(8'h43, 8'h43);
        wait_idle("t1");
        check("t1_data_held", data_in, 8'h43);

        // 2: burst, 3 clocks apart
        peak = 0;
        chk_spacing = 1'b1;
        spacing_valid = 1'b0;
        begin
            logic [7:0] burst [5] = '{8'h43, 8'h72, 8'hA5, 8'hE7, 8'hF4};
            foreach (burst[i]) begin
                send(burst[i], burst[i]);
                @(posedge clk);
            end
        end
        wait_idle("t2");
        check("t2_peak_count", peak, 4);

        // 3: overflow with ticks stopped; 08 and 09 are dropped
        tick_en = 1'b0;
        spacing_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            rx_data = 8'(i);
            rx_valid = 1'b1;
            if (i < 8) exp_q.push_back(8'(i));
            $display("send %02h expect %s", 8'(i), (i < 8) ? "echo" : "drop");
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("t3_count_full", count, 8);
        check("t3_overflow", overflow, 1);
        tick_en = 1'b1;
        wait_idle("t3");
        check("t3_overflow_sticky", overflow, 1);
        chk_spacing = 1'b0;

        // 4: XOR mask instance, level held 20 clocks
        rises_x = 0;
        @(posedge clk);
        #1;
        rx_x_data = 8'hA5;
        rx_x_valid = 1'b1;
        exp_x_q.push_back(8'h5A);
        $display("send_x A5 expect 5A");
        repeat (20) @(posedge clk);
        #1 rx_x_valid = 1'b0;
        wait_idle("t4");
        check("t4_single_echo", rises_x, 1);
        check("t4_x_drained", exp_x_q.size(), 0);

        pulse_reset("mid_rst");

        // 5: full FIFO, push coincides with the ARM pop
        tick_en = 1'b0;
        chk_width = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 8'h10 + 8'(i));
        repeat (3) @(negedge clk);
        check("t5_count_full", count, 8);
        @(posedge clk);
        #1;
        rx_data = 8'h18;
        rx_valid = 1'b1;
        man_tick = 1'b1;
        exp_q.push_back(8'h18);
        $display("send 18 with tick expect 18");
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        man_tick = 1'b0;
        @(negedge clk);
        check("t5_ready", ready, 1);
        check("t5_count_same", count, 8);
        check("t5_no_overflow", overflow, 0);
        tick_en = 1'b1;
        wait_idle("t5");
        chk_width = 1'b1;

        // 6: reset during HOLD
        send(8'h3C, 8'h3C);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 400 && !seen; i++) begin
                @(negedge clk);
                if (ready) seen = 1'b1;
            end
            check("t6_hold_reached", seen, 1);
        end
        chk_width = 1'b0;
        chk_hold = 1'b0;
        repeat (3) @(negedge clk);
        #10;
        rst = 1'b0;
        #1;
        check("t6_ready_async", ready, 0);
        check("t6_count", count, 0);
        check("t6_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_width = 1'b1;
        chk_hold = 1'b1;
        send(8'hE7, 8'hE7);
        wait_idle("t6");
        check("t6_data_held", data_in, 8'hE7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
